// File: rtl/pixel_request_queue_pkg.sv
// ---------------------------------------------------------------------------
// pixel_request_queue_pkg
// Shared definitions for the pixel request queue slice:
//   SCREEN_LINES_DEFAULT  - visible lines; pixel_y must be below this
//   FIFO_DEPTH_DEFAULT    - default request-buffer depth
//   GRAPHICS_MEM_PREFIX   - common name prefix for graphics memory images
//   issue_state_t         - issue FSM state encoding
//   pixel_req_t           - packed {x, y, rgb} request word (24 bits)
//   in_screen()           - clip test for a request line number
// ---------------------------------------------------------------------------
package pixel_request_queue_pkg;

  localparam int    SCREEN_LINES_DEFAULT = 192;
  localparam int    FIFO_DEPTH_DEFAULT   = 16;
  localparam string GRAPHICS_MEM_PREFIX  = "gfx_mem";

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } issue_state_t;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] rgb;
  } pixel_req_t;

  // True when the line number falls inside the visible screen.
  function automatic logic in_screen(input logic [7:0] y, input int lines);
    return int'(y) < lines;
  endfunction

endpackage

// File: rtl/pixel_request_queue_if.sv
// ---------------------------------------------------------------------------
// pixel_request_queue_if
// Bundles the CPU request handshake and the pixel_writer issue/complete
// signals of the pixel request queue.
//   req_valid/req_ready, req_x/req_y/req_rgb : CPU pixel-write request
//   clear_screen_done, pixel_wr_done         : status from pixel_writer
//   pixel_en, pixel_x/pixel_y/pixel_rgb      : issue strobe and pixel data
// modport slave  : the queue itself
// modport master : the environment (CPU side + pixel_writer)
// ---------------------------------------------------------------------------
interface pixel_request_queue_if;

  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_x;
  logic [7:0] req_y;
  logic [7:0] req_rgb;
  logic       clear_screen_done;
  logic       pixel_wr_done;
  logic       pixel_en;
  logic [7:0] pixel_x;
  logic [7:0] pixel_y;
  logic [7:0] pixel_rgb;

  modport slave (
    input  req_valid, req_x, req_y, req_rgb, clear_screen_done, pixel_wr_done,
    output req_ready, pixel_en, pixel_x, pixel_y, pixel_rgb
  );

  modport master (
    output req_valid, req_x, req_y, req_rgb, clear_screen_done, pixel_wr_done,
    input  req_ready, pixel_en, pixel_x, pixel_y, pixel_rgb
  );

endinterface

// File: rtl/pixel_request_queue_fifo.sv
// ---------------------------------------------------------------------------
// pixel_fifo
// Plain synchronous FIFO holding pending pixel requests.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push, wr_data : write one word (caller guarantees not full)
//   pop, rd_data  : rd_data always shows the head; pop advances it
//                   (caller guarantees not empty)
//   full, empty, count : occupancy status
// ---------------------------------------------------------------------------
module pixel_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 24
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Show-ahead read: the head word is visible before the pop edge so the
  // consumer can capture it on the same edge that removes it.
  assign rd_data = mem[rd_ptr_reg];
  assign count   = count_reg;
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);

endmodule

// File: rtl/pixel_request_queue.sv
// ---------------------------------------------------------------------------
// pixel_request_queue
// Buffers CPU pixel-write requests, drops off-screen ones, and issues them
// one at a time to the pixel_writer once the screen clear has finished.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus (slave) : request handshake and pixel_writer issue/complete signals
//   fifo_count  : current FIFO occupancy
//   drop_count  : clipped requests, saturating at 255
//   busy        : FIFO non-empty or a request is in flight
// ---------------------------------------------------------------------------
module pixel_request_queue
  import pixel_request_queue_pkg::*;
#(
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEFAULT,
  parameter int SCREEN_LINES = SCREEN_LINES_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  pixel_request_queue_if.slave         bus,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic [7:0]                   drop_count,
  output logic                         busy
);

  issue_state_t state_reg, state_next;
  pixel_req_t   pixel_reg;
  pixel_req_t   head;
  pixel_req_t   wr_req;
  logic [7:0]   drop_count_reg;
  logic         fifo_full, fifo_empty;
  logic         accept, in_range, push, clip, pop;

  // Clip stage: runs every cycle regardless of what the issue FSM is doing.
  assign accept   = bus.req_valid && bus.req_ready;
  assign in_range = in_screen(bus.req_y, SCREEN_LINES);
  assign push     = accept && in_range;
  assign clip     = accept && !in_range;
  assign wr_req   = '{x: bus.req_x, y: bus.req_y, rgb: bus.req_rgb};

  assign bus.req_ready = !fifo_full;

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(pixel_req_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (wr_req),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count_reg <= '0;
    end else if (clip && drop_count_reg != 8'hFF) begin
      drop_count_reg <= drop_count_reg + 8'd1;
    end
  end

  // Issue FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Issue FSM: next state. ISSUE holds if clear_screen_done drops in that
  // cycle so the already-popped request is delayed rather than lost.
  // WAIT_ACK ignores pixel_wr_done until it is seen low, which filters the
  // writer's stale done level; WAIT_DONE then reacts to a single-cycle pulse.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:      if (bus.clear_screen_done && !fifo_empty) state_next = ST_ISSUE;
      ST_ISSUE:     if (bus.clear_screen_done)                state_next = ST_WAIT_ACK;
      ST_WAIT_ACK:  if (!bus.pixel_wr_done)                   state_next = ST_WAIT_DONE;
      ST_WAIT_DONE: if (bus.pixel_wr_done)                    state_next = ST_IDLE;
      default:                                                state_next = ST_IDLE;
    endcase
  end

  // Issue FSM: outputs.
  always_comb begin
    pop          = (state_reg == ST_IDLE) && (state_next == ST_ISSUE);
    bus.pixel_en = (state_reg == ST_ISSUE) && bus.clear_screen_done;
    busy         = !fifo_empty || (state_reg != ST_IDLE);
  end

  // Issued pixel is captured on the pop edge and held until the next issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_reg <= '0;
    end else if (pop) begin
      pixel_reg <= head;
    end
  end

  assign bus.pixel_x   = pixel_reg.x;
  assign bus.pixel_y   = pixel_reg.y;
  assign bus.pixel_rgb = pixel_reg.rgb;
  assign drop_count    = drop_count_reg;

endmodule
